// File: rtl/pixel_mem_arbiter.sv
// Round-robin arbiter granting bla, fill and alpha pixel engines access to the
// single frame-buffer SRAM port with a fixed-length strobe and a one-cycle ack.
module pixel_mem_arbiter #(
  parameter int ADDR_W        = 19,
  parameter int DATA_W        = 24,
  parameter int ACCESS_CYCLES = 2
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              bla_req,
  input  logic [ADDR_W-1:0] bla_addr,
  input  logic [DATA_W-1:0] bla_wdata,
  input  logic              fill_req,
  input  logic [ADDR_W-1:0] fill_addr,
  input  logic [DATA_W-1:0] fill_wdata,
  input  logic              alpha_req,
  input  logic              alpha_rw,
  input  logic [ADDR_W-1:0] alpha_addr,
  input  logic [DATA_W-1:0] alpha_wdata,
  input  logic [DATA_W-1:0] sram_rdata,
  output logic              bla_ack,
  output logic              fill_ack,
  output logic              alpha_ack,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  output logic              sram_wen,
  output logic              sram_ren,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, ACK} state_t;
  typedef enum logic [1:0] {OWN_BLA, OWN_FILL, OWN_ALPHA} owner_t;

  localparam logic [3:0] CNT_LOAD = 4'(ACCESS_CYCLES - 1);

  state_t              state_q, state_d;
  owner_t              owner_q, owner_d;
  owner_t              last_q, last_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                rw_q, rw_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;

  owner_t              grant;
  logic                grant_vld;

  // Search order starts at the requester after the previous winner.
  always_comb begin
    grant     = OWN_BLA;
    grant_vld = 1'b0;
    unique case (last_q)
      OWN_BLA: begin
        if (fill_req)       begin grant = OWN_FILL;  grant_vld = 1'b1; end
        else if (alpha_req) begin grant = OWN_ALPHA; grant_vld = 1'b1; end
        else if (bla_req)   begin grant = OWN_BLA;   grant_vld = 1'b1; end
      end
      OWN_FILL: begin
        if (alpha_req)      begin grant = OWN_ALPHA; grant_vld = 1'b1; end
        else if (bla_req)   begin grant = OWN_BLA;   grant_vld = 1'b1; end
        else if (fill_req)  begin grant = OWN_FILL;  grant_vld = 1'b1; end
      end
      default: begin
        if (bla_req)        begin grant = OWN_BLA;   grant_vld = 1'b1; end
        else if (fill_req)  begin grant = OWN_FILL;  grant_vld = 1'b1; end
        else if (alpha_req) begin grant = OWN_ALPHA; grant_vld = 1'b1; end
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rw_d    = rw_q;
    rdata_d = rdata_q;
    unique case (state_q)
      IDLE: begin
        if (grant_vld) begin
          owner_d = grant;
          cnt_d   = CNT_LOAD;
          state_d = ACCESS;
          unique case (grant)
            OWN_BLA: begin
              addr_d  = bla_addr;
              wdata_d = bla_wdata;
              rw_d    = 1'b0;
            end
            OWN_FILL: begin
              addr_d  = fill_addr;
              wdata_d = fill_wdata;
              rw_d    = 1'b0;
            end
            default: begin
              addr_d  = alpha_addr;
              wdata_d = alpha_wdata;
              rw_d    = alpha_rw;
            end
          endcase
        end
      end
      ACCESS: begin
        if (cnt_q == 4'd0) begin
          if (rw_q) rdata_d = sram_rdata;
          state_d = ACK;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        last_d  = owner_q;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
      owner_q <= OWN_BLA;
      last_q  <= OWN_ALPHA;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rw_q    <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rw_q    <= rw_d;
      rdata_q <= rdata_d;
    end
  end

  // Outputs decode from registered state only, so requests never reach them combinationally.
  always_comb begin
    sram_wen   = (state_q == ACCESS) && !rw_q;
    sram_ren   = (state_q == ACCESS) && rw_q;
    sram_addr  = (state_q == ACCESS) ? addr_q  : '0;
    sram_wdata = (state_q == ACCESS) ? wdata_q : '0;
    bla_ack    = (state_q == ACK) && (owner_q == OWN_BLA);
    fill_ack   = (state_q == ACK) && (owner_q == OWN_FILL);
    alpha_ack  = (state_q == ACK) && (owner_q == OWN_ALPHA);
    busy       = (state_q != IDLE);
    rdata      = rdata_q;
  end

endmodule

// File: tb/tb_pixel_mem_arbiter.sv
// Scoreboard bench for pixel_mem_arbiter: requester agents drive transactions,
// a negedge monitor checks strobes, acks, read capture and ordering.
module tb_pixel_mem_arbiter;
  localparam int AW = 19;
  localparam int DW = 24;
  localparam int AC = 2;

  logic          clk = 1'b0;
  logic          n_rst;
  logic          bla_req, fill_req, alpha_req, alpha_rw;
  logic [AW-1:0] bla_addr, fill_addr, alpha_addr;
  logic [DW-1:0] bla_wdata, fill_wdata, alpha_wdata;
  logic [DW-1:0] sram_rdata = '0;
  logic          bla_ack, fill_ack, alpha_ack;
  logic [DW-1:0] rdata;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_wdata;
  logic          sram_wen, sram_ren, busy;

  logic [1:0]    s_req, s_bla_ack, s_fill_ack, s_alpha_ack, s_wen, s_ren, s_busy;
  logic [AW-1:0] s_baddr;
  logic [DW-1:0] s_bdata;
  logic [AW-1:0] s_sram_addr [2];
  logic [DW-1:0] s_sram_wdata [2];
  logic [DW-1:0] s_rdata [2];

  always #5 clk = ~clk;

  pixel_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .ACCESS_CYCLES(AC)) dut (
    .clk(clk), .n_rst(n_rst),
    .bla_req(bla_req), .bla_addr(bla_addr), .bla_wdata(bla_wdata),
    .fill_req(fill_req), .fill_addr(fill_addr), .fill_wdata(fill_wdata),
    .alpha_req(alpha_req), .alpha_rw(alpha_rw), .alpha_addr(alpha_addr),
    .alpha_wdata(alpha_wdata), .sram_rdata(sram_rdata),
    .bla_ack(bla_ack), .fill_ack(fill_ack), .alpha_ack(alpha_ack), .rdata(rdata),
    .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_wen(sram_wen),
    .sram_ren(sram_ren), .busy(busy)
  );

  pixel_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .ACCESS_CYCLES(1)) dut_ac1 (
    .clk(clk), .n_rst(n_rst),
    .bla_req(s_req[0]), .bla_addr(s_baddr), .bla_wdata(s_bdata),
    .fill_req(1'b0), .fill_addr('0), .fill_wdata('0),
    .alpha_req(1'b0), .alpha_rw(1'b0), .alpha_addr('0), .alpha_wdata('0),
    .sram_rdata(24'hFFFFFF),
    .bla_ack(s_bla_ack[0]), .fill_ack(s_fill_ack[0]), .alpha_ack(s_alpha_ack[0]),
    .rdata(s_rdata[0]), .sram_addr(s_sram_addr[0]), .sram_wdata(s_sram_wdata[0]),
    .sram_wen(s_wen[0]), .sram_ren(s_ren[0]), .busy(s_busy[0])
  );

  pixel_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .ACCESS_CYCLES(15)) dut_ac15 (
    .clk(clk), .n_rst(n_rst),
    .bla_req(s_req[1]), .bla_addr(s_baddr), .bla_wdata(s_bdata),
    .fill_req(1'b0), .fill_addr('0), .fill_wdata('0),
    .alpha_req(1'b0), .alpha_rw(1'b0), .alpha_addr('0), .alpha_wdata('0),
    .sram_rdata(24'hFFFFFF),
    .bla_ack(s_bla_ack[1]), .fill_ack(s_fill_ack[1]), .alpha_ack(s_alpha_ack[1]),
    .rdata(s_rdata[1]), .sram_addr(s_sram_addr[1]), .sram_wdata(s_sram_wdata[1]),
    .sram_wen(s_wen[1]), .sram_ren(s_ren[1]), .busy(s_busy[1])
  );

  typedef struct {
    int          who;        // 0 bla, 1 fill, 2 alpha
    logic        rw;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] srd;      // value the SRAM returns on the last strobe cycle
    logic [DW-1:0] exp_rdata;
  } txn_t;

  txn_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  int   cyc = 0;
  int   scnt = 0;
  int   bcnt = 0;
  int   last_ack_cyc = -1;
  bit   spacing_on = 1'b0;
  logic prev_strobe = 1'b0;

  function automatic txn_t mk(int who, logic rw, logic [AW-1:0] a, logic [DW-1:0] d,
                              logic [DW-1:0] srd, logic [DW-1:0] exp_rd);
    txn_t t;
    t.who = who; t.rw = rw; t.addr = a; t.wdata = d; t.srd = srd; t.exp_rdata = exp_rd;
    return t;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  task automatic fail(input string name, input string msg);
    checks++;
    errors++;
    $display("FAIL %s: %s (t=%0t)", name, msg, $time);
  endtask

  function automatic logic ack_of(int who);
    case (who)
      0:       return bla_ack;
      1:       return fill_ack;
      default: return alpha_ack;
    endcase
  endfunction

  task automatic drive(input int who, input logic v, input logic rw,
                       input logic [AW-1:0] a, input logic [DW-1:0] d);
    case (who)
      0: begin bla_req = v; bla_addr = a; bla_wdata = d; end
      1: begin fill_req = v; fill_addr = a; fill_wdata = d; end
      default: begin alpha_req = v; alpha_rw = rw; alpha_addr = a; alpha_wdata = d; end
    endcase
  endtask

  // Requester: holds req until ack, then presents the next item or drops.
  task automatic agent(input int who, input int n, input logic rw,
                       input logic [AW-1:0] a0, input logic [DW-1:0] d0);
    bit got;
    for (int i = 0; i < n; i++) begin
      drive(who, 1'b1, rw, AW'(a0 + AW'(i)), DW'(d0 + DW'(i)));
      got = 1'b0;
      for (int c = 0; c < 300 && !got; c++) begin
        @(negedge clk);
        if (ack_of(who)) got = 1'b1;
      end
      if (!got) fail("ack_timeout", $sformatf("requester %0d never acked", who));
    end
    drive(who, 1'b0, 1'b0, '0, '0);
  endtask

  // Monitor on the main instance.
  always @(negedge clk) begin
    logic strobe;
    logic [2:0] acks;
    txn_t t;
    cyc++;
    if (!n_rst) begin
      exp_q.delete();
      scnt = 0; bcnt = 0; prev_strobe = 1'b0;
      chk("reset_ctrl", {sram_wen, sram_ren, busy, alpha_ack, fill_ack, bla_ack}, 64'd0);
      chk("reset_bus", {sram_addr, sram_wdata}, 64'd0);
      chk("reset_rdata", rdata, 64'd0);
    end else begin
      strobe = sram_wen | sram_ren;
      acks   = {alpha_ack, fill_ack, bla_ack};
      chk("busy", busy, strobe | (|acks));
      if (busy) bcnt++;
      if (strobe) begin
        scnt++;
        if (exp_q.size() == 0) begin
          fail("unexpected_strobe", "strobe with no pending transaction");
          sram_rdata = 24'h5A5A5A;
        end else begin
          t = exp_q[0];
          chk("sram_addr", sram_addr, t.addr);
          if (!t.rw) chk("sram_wdata", sram_wdata, t.wdata);
          chk("strobe_kind", {sram_wen, sram_ren}, {~t.rw, t.rw});
          sram_rdata = (scnt == AC) ? t.srd : ~t.srd;
        end
      end else begin
        chk("bus_idle_zero", {sram_addr, sram_wdata}, 64'd0);
        sram_rdata = 24'h5A5A5A;
      end
      if (|acks) begin
        if (exp_q.size() == 0) begin
          fail("unexpected_ack", $sformatf("acks=%b", acks));
        end else begin
          t = exp_q.pop_front();
          chk("ack_owner", acks, 64'd1 << t.who);
          chk("strobe_width", scnt, AC);
          chk("ack_after_strobe", {prev_strobe, strobe}, 64'b10);
          chk("busy_cycles", bcnt, AC + 1);
          chk("rdata", rdata, t.exp_rdata);
          if (spacing_on && last_ack_cyc >= 0) chk("ack_spacing", cyc - last_ack_cyc, AC + 2);
          last_ack_cyc = cyc;
        end
        scnt = 0;
        bcnt = 0;
      end
      prev_strobe = strobe;
    end
  end

  task automatic sweep(input int idx, input int width);
    int w;
    bit seen;
    w = 0;
    seen = 1'b0;
    @(negedge clk);
    s_baddr = 19'h0ABCD;
    s_bdata = 24'h5A0000 | DW'(idx);
    s_req[idx] = 1'b1;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      if (s_wen[idx]) seen = 1'b1;
    end
    if (!seen) begin
      fail("sweep_timeout", $sformatf("instance %0d never strobed", idx));
      s_req[idx] = 1'b0;
    end else begin
      chk("sweep_addr", s_sram_addr[idx], 19'h0ABCD);
      chk("sweep_wdata", s_sram_wdata[idx], 24'h5A0000 | DW'(idx));
      while (s_wen[idx] && w < 40) begin
        if (s_bla_ack[idx]) fail("sweep_early_ack", "ack during strobe");
        w++;
        @(negedge clk);
      end
      chk("sweep_width", w, width);
      chk("sweep_ack", {s_bla_ack[idx], s_busy[idx]}, 64'b11);
      s_req[idx] = 1'b0;
      @(negedge clk);
      chk("sweep_ack_pulse", {s_bla_ack[idx], s_busy[idx]}, 64'd0);
      chk("sweep_other", {s_ren[idx], s_fill_ack[idx], s_alpha_ack[idx], s_rdata[idx]}, 64'd0);
    end
  endtask

  initial begin
    txn_t vecs[8];
    bit seen;

    vecs[0] = mk(2, 1'b1, 19'h4AFFF, 24'h999999, 24'h123456, 24'h123456);
    vecs[1] = mk(0, 1'b0, 19'h00010, 24'hFF0000, 24'hDEAD01, 24'h123456);
    vecs[2] = mk(1, 1'b0, 19'h7FFFF, 24'hFFFFFF, 24'hDEAD02, 24'h123456);
    vecs[3] = mk(2, 1'b0, 19'h00000, 24'h00FF00, 24'hDEAD03, 24'h123456);
    vecs[4] = mk(2, 1'b1, 19'h00001, 24'h000000, 24'hFFFFFF, 24'hFFFFFF);
    vecs[5] = mk(2, 1'b1, 19'h7FFFF, 24'h111111, 24'h000000, 24'h000000);
    vecs[6] = mk(0, 1'b0, 19'h4AFFF, 24'h0000FF, 24'hDEAD06, 24'h000000);
    vecs[7] = mk(2, 1'b0, 19'h12345, 24'hABCDEF, 24'hDEAD07, 24'h000000);

    n_rst = 1'b0;
    bla_req = 1'b0; fill_req = 1'b0; alpha_req = 1'b0; alpha_rw = 1'b0;
    bla_addr = '0; fill_addr = '0; alpha_addr = '0;
    bla_wdata = '0; fill_wdata = '0; alpha_wdata = '0;
    s_req = '0; s_baddr = '0; s_bdata = '0;
    repeat (3) @(negedge clk);
    n_rst = 1'b1;

    // All three requesting from reset: bla, fill, alpha, then bla again.
    spacing_on = 1'b1;
    last_ack_cyc = -1;
    exp_q.push_back(mk(0, 1'b0, 19'h00100, 24'h110000, 24'hD00000, 24'h000000));
    exp_q.push_back(mk(1, 1'b0, 19'h00200, 24'h220000, 24'hD00001, 24'h000000));
    exp_q.push_back(mk(2, 1'b1, 19'h00300, 24'h333333, 24'h0A0B0C, 24'h0A0B0C));
    exp_q.push_back(mk(0, 1'b0, 19'h00101, 24'h110001, 24'hD00002, 24'h0A0B0C));
    fork
      agent(0, 2, 1'b0, 19'h00100, 24'h110000);
      agent(1, 1, 1'b0, 19'h00200, 24'h220000);
      agent(2, 1, 1'b1, 19'h00300, 24'h333333);
    join
    spacing_on = 1'b0;

    // Single transactions, one requester at a time.
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(vecs[i]);
      agent(vecs[i].who, 1, vecs[i].rw, vecs[i].addr, vecs[i].wdata);
    end

    // bla and fill continuously: strict alternation starting with bla.
    spacing_on = 1'b1;
    last_ack_cyc = -1;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(mk(0, 1'b0, AW'(19'h01000 + i), DW'(24'h440000 + i), 24'hD10000, 24'h000000));
      exp_q.push_back(mk(1, 1'b0, AW'(19'h02000 + i), DW'(24'h550000 + i), 24'hD20000, 24'h000000));
    end
    fork
      agent(0, 3, 1'b0, 19'h01000, 24'h440000);
      agent(1, 3, 1'b0, 19'h02000, 24'h550000);
    join
    spacing_on = 1'b0;

    // Leave bla as last winner so fill would win next unless reset restores priority.
    exp_q.push_back(mk(0, 1'b0, 19'h00300, 24'h330000, 24'hD30000, 24'h000000));
    agent(0, 1, 1'b0, 19'h00300, 24'h330000);

    // Reset during the first strobe cycle of a fill write.
    exp_q.push_back(mk(1, 1'b0, 19'h11111, 24'h222222, 24'h000000, 24'h000000));
    drive(1, 1'b1, 1'b0, 19'h11111, 24'h222222);
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      if (sram_wen) seen = 1'b1;
    end
    if (!seen) fail("abort_timeout", "fill write never strobed");
    #2;
    n_rst = 1'b0;
    drive(1, 1'b0, 1'b0, '0, '0);
    #1;
    chk("abort_ctrl", {sram_wen, sram_ren, busy, alpha_ack, fill_ack, bla_ack}, 64'd0);
    chk("abort_bus", {sram_addr, sram_wdata}, 64'd0);
    repeat (3) @(negedge clk);
    n_rst = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("idle_after_reset", busy, 64'd0);
    end
    exp_q.push_back(mk(0, 1'b0, 19'h00400, 24'h440000, 24'hD40000, 24'h000000));
    exp_q.push_back(mk(1, 1'b0, 19'h00500, 24'h550000, 24'hD50000, 24'h000000));
    fork
      agent(0, 1, 1'b0, 19'h00400, 24'h440000);
      agent(1, 1, 1'b0, 19'h00500, 24'h550000);
    join
    @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 64'd0);

    sweep(0, 1);
    sweep(1, 15);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
